// File: rtl/vg75_ctrl.sv
// vg75_ctrl: CPU-side command/parameter controller for the VG75 (i8275-compatible)
// text display engine.
//
// It decodes command and parameter writes from the Radio-86 bus, holds the display
// configuration (geometry, cursor position/format, display enable), returns
// status/parameter reads and raises the end-of-frame interrupt.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   cs, we, rd, a0    bus select, write/read strobes, port select (1 = cmd/status)
//   din / dout        write data / registered read data (1-clock latency)
//   frame_end         end-of-frame pulse from the video generator
//   cfg_*             configuration outputs to the video generator
//   cursor_x/y        cursor position
//   display_en        video output enable
//   preset            one-clock pulse requesting a video counter reset
//   irq               interrupt request (IE & IR)
module vg75_ctrl #(
    parameter int unsigned RST_COLS  = 79,
    parameter int unsigned RST_ROWS  = 29,
    parameter int unsigned RST_LINES = 9,
    parameter int unsigned RST_ULINE = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       rd,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       frame_end,
    output logic [6:0] cfg_cols,
    output logic [5:0] cfg_rows,
    output logic [1:0] cfg_vrtc,
    output logic [3:0] cfg_lines,
    output logic [3:0] cfg_uline,
    output logic [1:0] cfg_curfmt,
    output logic [3:0] cfg_hrtc,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       display_en,
    output logic       preset,
    output logic       irq
);

    typedef enum logic [3:0] {
        StIdle,
        StRstP1,
        StRstP2,
        StRstP3,
        StRstP4,
        StCurP1,
        StCurP2,
        StLpR1,
        StLpR2
    } state_e;

    state_e     state_q;
    logic       ie_q;
    logic       ir_q;
    logic       ic_q;
    logic [6:0] sh_cols_q;
    logic [7:0] sh_p2_q;
    logic [7:0] sh_p3_q;
    logic [6:0] sh_curx_q;

    // Decoded strobes; a write wins over a simultaneous read.
    logic wr_cmd;
    logic wr_par;
    logic rd_sts;
    logic rd_par;
    logic frame_irq;

    assign wr_cmd    = cs & we & a0;
    assign wr_par    = cs & we & ~a0;
    assign rd_sts    = cs & rd & ~we & a0;
    assign rd_par    = cs & rd & ~we & ~a0;
    assign frame_irq = frame_end & display_en;

    assign irq = ie_q & ir_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ie_q       <= 1'b0;
            ir_q       <= 1'b0;
            ic_q       <= 1'b0;
            sh_cols_q  <= '0;
            sh_p2_q    <= '0;
            sh_p3_q    <= '0;
            sh_curx_q  <= '0;
            dout       <= '0;
            cfg_cols   <= 7'(RST_COLS);
            cfg_rows   <= 6'(RST_ROWS);
            cfg_vrtc   <= '0;
            cfg_lines  <= 4'(RST_LINES);
            cfg_uline  <= 4'(RST_ULINE);
            cfg_curfmt <= '0;
            cfg_hrtc   <= '0;
            cursor_x   <= '0;
            cursor_y   <= '0;
            display_en <= 1'b0;
            preset     <= 1'b0;
        end else begin
            preset <= 1'b0;

            if (frame_irq) begin
                ir_q <= 1'b1;
            end

            if (wr_cmd) begin
                // Any command abandons a partially written parameter sequence.
                state_q <= StIdle;
                unique case (din[7:5])
                    3'b000: begin
                        display_en <= 1'b0;
                        ie_q       <= 1'b0;
                        state_q    <= StRstP1;
                    end
                    3'b001: begin
                        display_en <= 1'b1;
                        ie_q       <= 1'b1;
                    end
                    3'b010: display_en <= 1'b0;
                    3'b011: state_q <= StLpR1;
                    3'b100: state_q <= StCurP1;
                    3'b101: ie_q <= 1'b1;
                    3'b110: ie_q <= 1'b0;
                    3'b111: preset <= 1'b1;
                endcase
            end else if (wr_par) begin
                case (state_q)
                    StRstP1: begin
                        sh_cols_q <= din[6:0];
                        state_q   <= StRstP2;
                    end
                    StRstP2: begin
                        sh_p2_q <= din;
                        state_q <= StRstP3;
                    end
                    StRstP3: begin
                        sh_p3_q <= din;
                        state_q <= StRstP4;
                    end
                    StRstP4: begin
                        // Whole geometry commits at once from the shadows.
                        cfg_cols   <= sh_cols_q;
                        cfg_vrtc   <= sh_p2_q[7:6];
                        cfg_rows   <= sh_p2_q[5:0];
                        cfg_uline  <= sh_p3_q[7:4];
                        cfg_lines  <= sh_p3_q[3:0];
                        cfg_curfmt <= din[5:4];
                        cfg_hrtc   <= din[3:0];
                        state_q    <= StIdle;
                    end
                    StCurP1: begin
                        sh_curx_q <= din[6:0];
                        state_q   <= StCurP2;
                    end
                    StCurP2: begin
                        cursor_x <= sh_curx_q;
                        cursor_y <= din[5:0];
                        state_q  <= StIdle;
                    end
                    default: ic_q <= 1'b1;
                endcase
            end else if (rd_sts) begin
                dout <= {1'b0, ie_q, ir_q, 1'b0, ic_q, display_en, 2'b00};
                ic_q <= 1'b0;
                // A frame end landing on the read keeps the new interrupt pending.
                if (!frame_irq) begin
                    ir_q <= 1'b0;
                end
            end else if (rd_par) begin
                dout <= 8'h00;
                case (state_q)
                    StLpR1:  state_q <= StLpR2;
                    StLpR2:  state_q <= StIdle;
                    default: ic_q <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vg75_ctrl.sv
// tb_vg75_ctrl: directed self-checking bench for vg75_ctrl.
module tb_vg75_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       rd = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       frame_end = 1'b0;
    logic [7:0] dout;
    logic [6:0] cfg_cols;
    logic [5:0] cfg_rows;
    logic [1:0] cfg_vrtc;
    logic [3:0] cfg_lines;
    logic [3:0] cfg_uline;
    logic [1:0] cfg_curfmt;
    logic [3:0] cfg_hrtc;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       display_en;
    logic       preset;
    logic       irq;

    int passed = 0;
    int total  = 0;

    vg75_ctrl #(
        .RST_COLS (79),
        .RST_ROWS (29),
        .RST_LINES(9),
        .RST_ULINE(7)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cs        (cs),
        .we        (we),
        .rd        (rd),
        .a0        (a0),
        .din       (din),
        .dout      (dout),
        .frame_end (frame_end),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .cfg_vrtc  (cfg_vrtc),
        .cfg_lines (cfg_lines),
        .cfg_uline (cfg_uline),
        .cfg_curfmt(cfg_curfmt),
        .cfg_hrtc  (cfg_hrtc),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .display_en(display_en),
        .preset    (preset),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bus cycles: strobes are raised on a falling edge and dropped on the next,
    // so each straddles exactly one rising edge; checks then run at that next fall.
    task automatic bus_wr(input logic port, input logic [7:0] data);
        @(negedge clock);
        cs = 1'b1; we = 1'b1; a0 = port; din = data;
        @(negedge clock);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic port);
        @(negedge clock);
        cs = 1'b1; rd = 1'b1; a0 = port;
        @(negedge clock);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cols", 32'(cfg_cols), 79);
        chk("rst_rows", 32'(cfg_rows), 29);
        chk("rst_lines", 32'(cfg_lines), 9);
        chk("rst_uline", 32'(cfg_uline), 7);
        chk("rst_vrtc", 32'(cfg_vrtc), 0);
        chk("rst_curfmt", 32'(cfg_curfmt), 0);
        chk("rst_hrtc", 32'(cfg_hrtc), 0);
        chk("rst_cursor", 32'({cursor_x, cursor_y}), 0);
        chk("rst_den", 32'(display_en), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_preset", 32'(preset), 0);
        bus_rd(1'b1);
        chk("rst_status", 32'(dout), 8'h00);

        // Geometry: nothing moves until P4
        bus_wr(1'b1, 8'h00);
        bus_wr(1'b0, 8'h4F);
        bus_wr(1'b0, 8'h1D);
        bus_wr(1'b0, 8'h99);
        chk("p3_uline_held", 32'(cfg_uline), 7);
        chk("p3_curfmt_held", 32'(cfg_curfmt), 0);
        bus_wr(1'b0, 8'h93);
        chk("p4_cols", 32'(cfg_cols), 79);
        chk("p4_vrtc", 32'(cfg_vrtc), 0);
        chk("p4_rows", 32'(cfg_rows), 29);
        chk("p4_uline", 32'(cfg_uline), 9);
        chk("p4_lines", 32'(cfg_lines), 9);
        chk("p4_curfmt", 32'(cfg_curfmt), 1);
        chk("p4_hrtc", 32'(cfg_hrtc), 3);

        // Cursor: aborted sequence must never leak 0x0A
        bus_wr(1'b1, 8'h80);
        bus_wr(1'b0, 8'h0A);
        chk("cur_p1_held", 32'({cursor_x, cursor_y}), 0);
        bus_wr(1'b1, 8'h80);
        bus_wr(1'b0, 8'h05);
        chk("cur_p1b_held", 32'({cursor_x, cursor_y}), 0);
        bus_wr(1'b0, 8'h03);
        chk("cur_x", 32'(cursor_x), 5);
        chk("cur_y", 32'(cursor_y), 3);

        // START + frame interrupt
        bus_wr(1'b1, 8'h20);
        chk("start_den", 32'(display_en), 1);
        chk("start_irq0", 32'(irq), 0);
        pulse_frame();
        chk("frame_irq", 32'(irq), 1);
        bus_rd(1'b1);
        chk("sts_ir", 32'(dout), 8'h64);
        chk("sts_ir_clr_irq", 32'(irq), 0);
        bus_rd(1'b1);
        chk("sts_after", 32'(dout), 8'h44);

        // Parameter write while idle flags IC only
        bus_wr(1'b0, 8'h12);
        chk("ic_cols_kept", 32'(cfg_cols), 79);
        chk("ic_uline_kept", 32'(cfg_uline), 9);
        bus_rd(1'b1);
        chk("sts_ic", 32'(dout), 8'h4C);
        bus_rd(1'b1);
        chk("sts_ic_clr", 32'(dout), 8'h44);

        // PRESET is a single-clock pulse
        bus_wr(1'b1, 8'hE0);
        chk("preset_hi", 32'(preset), 1);
        @(negedge clock);
        chk("preset_lo", 32'(preset), 0);

        // Frame end with display disabled is ignored
        bus_wr(1'b1, 8'h40);
        chk("stop_den", 32'(display_en), 0);
        pulse_frame();
        chk("stop_frame_irq", 32'(irq), 0);
        bus_rd(1'b1);
        chk("sts_stopped", 32'(dout), 8'h40);

        // Status read coinciding with frame end: IR survives
        bus_wr(1'b1, 8'h20);
        @(negedge clock);
        cs = 1'b1; rd = 1'b1; a0 = 1'b1; frame_end = 1'b1;
        @(negedge clock);
        cs = 1'b0; rd = 1'b0; frame_end = 1'b0;
        chk("race_dout", 32'(dout), 8'h44);
        chk("race_irq", 32'(irq), 1);

        // we+rd together: DI executes, read dropped
        @(negedge clock);
        cs = 1'b1; we = 1'b1; rd = 1'b1; a0 = 1'b1; din = 8'hC0;
        @(negedge clock);
        cs = 1'b0; we = 1'b0; rd = 1'b0;
        chk("wr_rd_irq", 32'(irq), 0);
        chk("wr_rd_dout", 32'(dout), 8'h44);

        // Deselected START ignored
        @(negedge clock);
        cs = 1'b0; we = 1'b1; a0 = 1'b1; din = 8'h20;
        @(negedge clock);
        we = 1'b0;
        chk("nocs_irq", 32'(irq), 0);
        bus_rd(1'b1);
        chk("nocs_sts", 32'(dout), 8'h24);

        // Async reset in the middle of RST_P2
        bus_wr(1'b1, 8'h00);
        bus_wr(1'b0, 8'h10);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cols", 32'(cfg_cols), 79);
        chk("mid_rst_uline", 32'(cfg_uline), 7);
        chk("mid_rst_lines", 32'(cfg_lines), 9);
        chk("mid_rst_cursor", 32'({cursor_x, cursor_y}), 0);
        chk("mid_rst_dout", 32'(dout), 0);
        @(negedge clock);
        reset = 1'b0;
        bus_wr(1'b0, 8'h12);
        chk("post_rst_cols", 32'(cfg_cols), 79);
        bus_rd(1'b1);
        chk("post_rst_ic", 32'(dout), 8'h08);

        // Light pen: two parameter reads are legal, a third flags IC
        bus_wr(1'b1, 8'h60);
        bus_rd(1'b0);
        chk("lp_r1", 32'(dout), 0);
        bus_rd(1'b0);
        chk("lp_r2", 32'(dout), 0);
        bus_rd(1'b1);
        chk("lp_sts", 32'(dout), 8'h00);
        bus_rd(1'b0);
        bus_rd(1'b1);
        chk("lp_extra_ic", 32'(dout), 8'h08);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
